// File: rtl/logic_unit_pipe.sv
// Registered eight-function logic unit with an optional accumulator operand and a
// DEPTH-entry result FIFO, with valid/ready handshakes on input and output.
module logic_unit_pipe #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             acc,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] acc_q
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [PW:0]      count_q, count_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic             accept;
    logic             pop;
    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] result;

    function automatic logic [WIDTH-1:0] logic_op(
        input logic [2:0]       sel,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        r = '0;
        case (sel)
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b010:  r = a ^ b;
            3'b011:  r = ~(a | b);
            3'b100:  r[0] = (|a) && (|b);
            3'b101:  r[0] = (|a) || (|b);
            3'b110:  r = ~a;
            default: r = a & ~b;
        endcase
        return r;
    endfunction

    // Ready depends only on occupancy, so a full FIFO needs one drain cycle first.
    assign in_ready  = enable && !rst && (count_q < DEPTH_C);
    assign out_valid = (count_q != '0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign a_eff  = acc ? acc_q : A;
    assign result = logic_op(op, a_eff, B);

    assign out  = out_valid ? mem_q[head_q] : '0;
    assign zero = (out == '0);

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        acc_d   = acc_q;
        mem_d   = mem_q;
        if (accept) begin
            mem_d[tail_q] = result;
            tail_d        = tail_q + 1'b1;
            acc_d         = result;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state and accumulator reset; storage is qualified by count instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            acc_q   <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            acc_q   <= acc_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe (WIDTH=4, DEPTH=2) with immediate-assertion checks.
module tb_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic       acc;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] out;
    logic       zero;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] acc_q;

    int tests = 0;
    int fails = 0;

    logic [3:0] exp_ops [8];

    logic_unit_pipe #(.WIDTH(4), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .acc       (acc),
        .A         (A),
        .B         (B),
        .out       (out),
        .zero      (zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_q     (acc_q)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_ops[0] = 4'b1000; exp_ops[1] = 4'b1110; exp_ops[2] = 4'b0110; exp_ops[3] = 4'b0001;
        exp_ops[4] = 4'b0001; exp_ops[5] = 4'b0001; exp_ops[6] = 4'b0011; exp_ops[7] = 4'b0100;

        rst = 1'b1; enable = 1'b1; in_valid = 1'b1; op = 3'd1; acc = 1'b0;
        A = 4'b1111; B = 4'b1111; out_ready = 1'b0;

        // Reset held two cycles with a valid input presented
        tick();
        tick();
        chk_bit("rst_in_ready", in_ready, 1'b0);
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk_val("rst_out", out, 4'b0000);
        chk_bit("rst_zero", zero, 1'b1);
        chk_val("rst_acc_q", acc_q, 4'b0000);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk_bit("post_rst_in_ready", in_ready, 1'b1);

        // All eight operations, streaming with out_ready=1
        A = 4'b1100; B = 4'b1010; out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            #1;
            chk_bit($sformatf("op%0d_in_ready", i), in_ready, 1'b1);
            tick();
            chk_bit($sformatf("op%0d_out_valid", i), out_valid, 1'b1);
            chk_val($sformatf("op%0d_out", i), out, exp_ops[i]);
        end
        in_valid = 1'b0;
        tick();
        chk_bit("ops_drained", out_valid, 1'b0);

        // Logical versus bitwise AND on disjoint operands
        A = 4'b0100; B = 4'b0010; op = 3'b000; in_valid = 1'b1;
        tick();
        chk_val("band_out", out, 4'b0000);
        chk_bit("band_zero", zero, 1'b1);
        chk_bit("band_valid", out_valid, 1'b1);
        op = 3'b100;
        tick();
        chk_val("land_out", out, 4'b0001);
        chk_bit("land_zero", zero, 1'b0);
        in_valid = 1'b0;
        tick();
        chk_bit("land_drained", out_valid, 1'b0);

        // Accumulate chain; A is set to junk once acc=1 to show it is ignored
        A = 4'b0001; B = 4'b0000; op = 3'b001; acc = 1'b0; in_valid = 1'b1;
        tick();
        chk_val("acc1_out", out, 4'b0001);
        chk_val("acc1_acc_q", acc_q, 4'b0001);
        A = 4'b1111; B = 4'b0010; op = 3'b001; acc = 1'b1;
        tick();
        chk_val("acc2_out", out, 4'b0011);
        B = 4'b0011; op = 3'b010;
        tick();
        chk_val("acc3_out", out, 4'b0000);
        chk_bit("acc3_zero", zero, 1'b1);
        chk_bit("acc3_valid", out_valid, 1'b1);
        chk_val("acc3_acc_q", acc_q, 4'b0000);
        in_valid = 1'b0; acc = 1'b0;
        tick();
        chk_bit("acc_drained", out_valid, 1'b0);

        // Backpressure: fill, block third, single pop, refill, drain in order
        out_ready = 1'b0; op = 3'b001; B = 4'b0000; in_valid = 1'b1;
        A = 4'b0001;
        tick();
        chk_val("bp_head1", out, 4'b0001);
        A = 4'b0010;
        #1;
        chk_bit("bp_ready2", in_ready, 1'b1);
        tick();
        A = 4'b0100;
        chk_bit("bp_full_ready", in_ready, 1'b0);
        tick();
        chk_bit("bp_blocked_ready", in_ready, 1'b0);
        chk_val("bp_blocked_head", out, 4'b0001);
        chk_val("bp_blocked_acc_q", acc_q, 4'b0010);
        out_ready = 1'b1;
        #1;
        chk_bit("bp_pop_cycle_ready", in_ready, 1'b0);
        tick();
        out_ready = 1'b0;
        chk_bit("bp_after_pop_ready", in_ready, 1'b1);
        chk_val("bp_after_pop_head", out, 4'b0010);
        tick();
        in_valid = 1'b0;
        chk_bit("bp_refilled_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        chk_val("bp_drain1", out, 4'b0010);
        tick();
        chk_val("bp_drain2", out, 4'b0100);
        tick();
        chk_bit("bp_drained", out_valid, 1'b0);
        chk_val("bp_drained_out", out, 4'b0000);

        // Simultaneous accept and pop at count=1, then enable=0 drain
        out_ready = 1'b0; in_valid = 1'b1; A = 4'b0011;
        tick();
        chk_val("sim_head", out, 4'b0011);
        A = 4'b0101; out_ready = 1'b1;
        tick();
        chk_bit("sim_valid", out_valid, 1'b1);
        chk_val("sim_out", out, 4'b0101);
        chk_bit("sim_count1_ready", in_ready, 1'b1);
        out_ready = 1'b0; A = 4'b0110;
        tick();
        chk_bit("sim_full_ready", in_ready, 1'b0);
        enable = 1'b0; A = 4'b1111; out_ready = 1'b1;
        tick();
        chk_val("dis_drain1", out, 4'b0110);
        chk_bit("dis_ready", in_ready, 1'b0);
        tick();
        chk_bit("dis_drained", out_valid, 1'b0);
        chk_bit("dis_zero", zero, 1'b1);
        chk_val("dis_acc_hold", acc_q, 4'b0110);

        // Reset with two entries queued
        enable = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
        A = 4'b1000;
        tick();
        A = 4'b1001;
        tick();
        chk_val("rq_head", out, 4'b1000);
        in_valid = 1'b0; rst = 1'b1;
        tick();
        chk_bit("rq_out_valid", out_valid, 1'b0);
        chk_val("rq_out", out, 4'b0000);
        chk_val("rq_acc_q", acc_q, 4'b0000);
        chk_bit("rq_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk_bit("rq_release_ready", in_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
